// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry valid/ready skid buffer with registered ready
// in_ready, out_valid and level decode from state only, so no combinational path crosses the stage.
module pipe_skid_reg #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_fire;
    logic                  out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        level = 2'd0;
        case (state_q)
            EMPTY:   level = 2'd0;
            BUSY:    level = 2'd1;
            FULL:    level = 2'd2;
            default: level = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Upstream stays blocked this cycle; the skid word moves forward first.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed self-checking bench for pipe_skid_reg
module tb_pipe_skid_reg;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  level;

    int total = 0;
    int bad   = 0;

    pipe_skid_reg #(.DATA_WIDTH(32), .RESET_VALUE(32'h0)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .level    (level)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic v, input logic r, input logic [1:0] l);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, r});
        chk({tag, "_level"}, {30'd0, level}, {30'd0, l});
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        tick();
        tick();
        chk_state("rst_hold", 1'b0, 1'b1, 2'd0);
        chk("rst_hold_data", out_data, 32'h0);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk_state("rst_rel", 1'b0, 1'b1, 2'd0);
        chk("rst_rel_data", out_data, 32'h0);

        // single beat
        in_valid  = 1'b1;
        in_data   = 32'h0000_0011;
        out_ready = 1'b1;
        tick();
        chk_state("single", 1'b1, 1'b1, 2'd1);
        chk("single_data", out_data, 32'h11);
        in_valid = 1'b0;
        tick();
        chk_state("single_gone", 1'b0, 1'b1, 2'd0);

        // streaming
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            tick();
            chk_state("stream", 1'b1, 1'b1, 2'd1);
            chk("stream_data", out_data, i);
        end
        in_valid = 1'b0;
        tick();
        chk_state("stream_end", 1'b0, 1'b1, 2'd0);

        // backpressure fill
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        chk_state("fill_a", 1'b1, 1'b1, 2'd1);
        chk("fill_a_data", out_data, 32'hA);
        in_data = 32'hB;
        tick();
        chk_state("fill_b", 1'b1, 1'b0, 2'd2);
        chk("fill_b_data", out_data, 32'hA);
        in_data = 32'hC;
        tick();
        chk_state("fill_c_blocked", 1'b1, 1'b0, 2'd2);
        chk("fill_c_data", out_data, 32'hA);
        tick();
        chk_state("fill_stall", 1'b1, 1'b0, 2'd2);
        chk("fill_stall_data", out_data, 32'hA);

        // drain from FULL: A leaves on this edge, B moves to main
        out_ready = 1'b1;
        tick();
        chk_state("drain_b", 1'b1, 1'b1, 2'd1);
        chk("drain_b_data", out_data, 32'hB);
        tick();
        chk_state("drain_c", 1'b1, 1'b1, 2'd1);
        chk("drain_c_data", out_data, 32'hC);
        in_valid = 1'b0;
        tick();
        chk_state("drain_end", 1'b0, 1'b1, 2'd0);

        // reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        chk_state("rfull_pre", 1'b1, 1'b0, 2'd2);
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        chk_state("rfull_rst", 1'b0, 1'b1, 2'd0);
        chk("rfull_rst_data", out_data, 32'h0);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("rfull_idle", 1'b0, 1'b1, 2'd0);
        end
        in_valid = 1'b1;
        in_data  = 32'hD;
        tick();
        chk_state("rfull_new", 1'b1, 1'b1, 2'd1);
        chk("rfull_new_data", out_data, 32'hD);
        in_valid = 1'b0;
        tick();
        chk_state("rfull_end", 1'b0, 1'b1, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
